// File: rtl/snake_vga_pkg.sv
// Shared screen geometry, colour constants and arbiter state type for the snake VGA path.
package snake_vga_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] GREEN = 3'b010;

   typedef enum logic {
      ARB,
      CLEAR
   } arb_state_t;

endpackage

// File: rtl/screen_sweep.sv
// Raster counter that walks every pixel once, x fastest, one pixel per cycle.
// Shared by the clear engine and the game-over fill.
module screen_sweep
   import snake_vga_pkg::*;
#(
   parameter int W = SCREEN_W,
   parameter int H = SCREEN_H
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic       busy,
   output logic       last,
   output logic       done
);

   localparam logic [7:0] X_LAST = 8'(W - 1);
   localparam logic [6:0] Y_LAST = 7'(H - 1);

   logic [7:0] x_reg;
   logic [6:0] y_reg;
   logic       busy_reg;
   logic       done_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         x_reg    <= '0;
         y_reg    <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (busy_reg) begin
            if (x_reg == X_LAST) begin
               x_reg <= '0;
               if (y_reg == Y_LAST) begin
                  y_reg    <= '0;
                  busy_reg <= 1'b0;
                  done_reg <= 1'b1;
               end else begin
                  y_reg <= y_reg + 7'd1;
               end
            end else begin
               x_reg <= x_reg + 8'd1;
            end
         end else if (start) begin
            // A start while already sweeping is deliberately ignored.
            x_reg    <= '0;
            y_reg    <= '0;
            busy_reg <= 1'b1;
         end
      end
   end

   assign x    = x_reg;
   assign y    = y_reg;
   assign busy = busy_reg;
   assign last = busy_reg && (x_reg == X_LAST) && (y_reg == Y_LAST);
   assign done = done_reg;

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin share of the VGA adapter write port with a built-in full-screen clear.
// Optional build macro PLOT_CLIP_EN suppresses writes of granted off-screen pixels.
module vga_plot_arbiter #(
   parameter int         NUM_REQ   = 3,
   parameter int         SCREEN_W  = snake_vga_pkg::SCREEN_W,
   parameter int         SCREEN_H  = snake_vga_pkg::SCREEN_H,
   parameter logic [2:0] BG_COLOUR = snake_vga_pkg::BLACK
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_x,
   input  logic [7*NUM_REQ-1:0] req_y,
   input  logic [3*NUM_REQ-1:0] req_colour,
   output logic [NUM_REQ-1:0]   gnt,
   input  logic                 clear_go,
   output logic                 clear_busy,
   output logic                 clear_done,
   output logic [7:0]           x,
   output logic [6:0]           y,
   output logic [2:0]           colour,
   output logic                 writeEn
);

   import snake_vga_pkg::arb_state_t;
   import snake_vga_pkg::ARB;
   import snake_vga_pkg::CLEAR;

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW    = IDX_W + 1;

   arb_state_t       state_reg;
   logic [IDX_W-1:0] ptr_reg;
   logic [7:0]       x_reg;
   logic [6:0]       y_reg;
   logic [2:0]       colour_reg;
   logic             we_reg;
   logic             clear_busy_reg;
   logic             clear_done_reg;
   logic             drain_reg;

   logic [7:0] rx [NUM_REQ];
   logic [6:0] ry [NUM_REQ];
   logic [2:0] rc [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign rx[gi] = req_x[8*gi +: 8];
      assign ry[gi] = req_y[7*gi +: 7];
      assign rc[gi] = req_colour[3*gi +: 3];
   end

   // ptr_reg is the index where the next search begins (last granted + 1).
   logic [IDX_W-1:0] sel_idx;
   logic             sel_valid;
   logic [CW-1:0]    cand;

   always_comb begin
      sel_idx   = '0;
      sel_valid = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_reg} + CW'(k);
         if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
         if (!sel_valid && req[cand[IDX_W-1:0]]) begin
            sel_valid = 1'b1;
            sel_idx   = cand[IDX_W-1:0];
         end
      end
   end

   logic arb_go;
   assign arb_go = rst && (state_reg == ARB) && !clear_go && sel_valid;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign gnt[gi] = arb_go && (sel_idx == IDX_W'(gi));
   end

   logic [7:0] sel_x;
   logic [6:0] sel_y;
   logic [2:0] sel_c;
   assign sel_x = rx[sel_idx];
   assign sel_y = ry[sel_idx];
   assign sel_c = rc[sel_idx];

   logic       sweep_start;
   logic [7:0] sweep_x;
   logic [6:0] sweep_y;
   logic       sweep_busy;
   logic       sweep_last;
   logic       sweep_done;

   assign sweep_start = (state_reg == ARB) && clear_go;

   screen_sweep #(
      .W (SCREEN_W),
      .H (SCREEN_H)
   ) u_sweep (
      .clk   (clk),
      .rst   (rst),
      .start (sweep_start),
      .x     (sweep_x),
      .y     (sweep_y),
      .busy  (sweep_busy),
      .last  (sweep_last),
      .done  (sweep_done)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= ARB;
         ptr_reg        <= '0;
         x_reg          <= '0;
         y_reg          <= '0;
         colour_reg     <= '0;
         we_reg         <= 1'b0;
         clear_busy_reg <= 1'b0;
         clear_done_reg <= 1'b0;
         drain_reg      <= 1'b0;
      end else begin
         // drain_reg marks the cycle the final sweep pixel sits on the port.
         drain_reg      <= sweep_last;
         clear_done_reg <= drain_reg;
         clear_busy_reg <= sweep_busy;
         case (state_reg)
            ARB: begin
               if (clear_go) begin
                  state_reg <= CLEAR;
                  we_reg    <= 1'b0;
               end else if (sel_valid) begin
                  ptr_reg <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
`ifdef PLOT_CLIP_EN
                  if ((int'(sel_x) >= SCREEN_W) || (int'(sel_y) >= SCREEN_H)) begin
                     we_reg <= 1'b0;
                  end else begin
                     x_reg      <= sel_x;
                     y_reg      <= sel_y;
                     colour_reg <= sel_c;
                     we_reg     <= 1'b1;
                  end
`else
                  x_reg      <= sel_x;
                  y_reg      <= sel_y;
                  colour_reg <= sel_c;
                  we_reg     <= 1'b1;
`endif
               end else begin
                  we_reg <= 1'b0;
               end
            end
            CLEAR: begin
               if (sweep_busy) begin
                  x_reg      <= sweep_x;
                  y_reg      <= sweep_y;
                  colour_reg <= BG_COLOUR;
                  we_reg     <= 1'b1;
               end else begin
                  we_reg <= 1'b0;
               end
               if (sweep_done) state_reg <= ARB;
            end
            default: state_reg <= ARB;
         endcase
      end
   end

   assign x          = x_reg;
   assign y          = y_reg;
   assign colour     = colour_reg;
   assign writeEn    = we_reg;
   assign clear_busy = clear_busy_reg;
   assign clear_done = clear_done_reg;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed self-checking bench for vga_plot_arbiter (3 requesters, 160x120 screen).
module tb_vga_plot_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [23:0] req_x;
   logic [20:0] req_y;
   logic [8:0]  req_colour;
   logic [2:0]  gnt;
   logic        clear_go;
   logic        clear_busy;
   logic        clear_done;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        writeEn;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_plot_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_colour (req_colour),
      .gnt        (gnt),
      .clear_go   (clear_go),
      .clear_busy (clear_busy),
      .clear_done (clear_done),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .writeEn    (writeEn)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] px, input logic [6:0] py,
                          input logic [2:0] pc);
      req_x[8*i +: 8]      = px;
      req_y[7*i +: 7]      = py;
      req_colour[3*i +: 3] = pc;
   endtask

   initial begin
      logic [2:0] exp_gnt [6];
      logic [7:0] exp_x   [6];
      int ex, ey, nw, pix_bad, gnt_bad, done_seen, bad_cnt;

      exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp_x   = '{8'd1, 8'd3, 8'd5, 8'd1, 8'd3, 8'd5};

      // Reset held with all requests asserted
      rst = 1'b0; req = 3'b111; req_x = '0; req_y = '0; req_colour = '0; clear_go = 1'b0;
      repeat (3) tick;
      chk("rst_gnt", gnt, 0);
      chk("rst_we", writeEn, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_colour", colour, 0);
      chk("rst_busy", clear_busy, 0);
      chk("rst_done", clear_done, 0);
      $display("reset: gnt=%b we=%b", gnt, writeEn);
      rst = 1'b1; req = 3'b000;
      tick;

      // Single requester
      set_req(1, 8'd10, 7'd20, 3'b100);
      req = 3'b010;
      #1;
      chk("single_gnt", gnt, 3'b010);
      tick;
      chk("single_x", x, 10);
      chk("single_y", y, 20);
      chk("single_colour", colour, 4);
      chk("single_we", writeEn, 1);
      $display("single: x=%0d y=%0d colour=%0d we=%b", x, y, colour, writeEn);
      req = 3'b000;
      #1;
      chk("idle_gnt", gnt, 0);
      tick;
      chk("idle_we", writeEn, 0);
      chk("idle_hold_x", x, 10);

      // Round-robin from a fresh reset
      rst = 1'b0;
      tick;
      rst = 1'b1;
      set_req(0, 8'd1, 7'd2, 3'd1);
      set_req(1, 8'd3, 7'd4, 3'd2);
      set_req(2, 8'd5, 7'd6, 3'd3);
      req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_gnt", gnt, exp_gnt[k]);
         tick;
         chk("rr_we", writeEn, 1);
         chk("rr_x", x, exp_x[k]);
         $display("rr step %0d: x=%0d y=%0d we=%b", k, x, y, writeEn);
      end

      // Clear with a pending request, plus an ignored clear_go mid-sweep
      req = 3'b001;
      clear_go = 1'b1;
      #1;
      chk("clr_gnt", gnt, 0);
      tick;
      clear_go = 1'b0;
      ex = 0; ey = 0; nw = 0; pix_bad = 0; gnt_bad = 0; done_seen = 0;
      for (int c = 0; c < 19400; c++) begin
         if (clear_done) begin
            done_seen = 1;
            break;
         end
         if (gnt != 3'b000) gnt_bad++;
         if (writeEn) begin
            if (x != 8'(ex) || y != 7'(ey) || colour != 3'b000 || !clear_busy) pix_bad++;
            nw++;
            ex++;
            if (ex == 160) begin
               ex = 0;
               ey++;
            end
         end
         clear_go = (nw == 1000 && writeEn);
         tick;
      end
      clear_go = 1'b0;
      chk("clr_done_seen", done_seen, 1);
      chk("clr_writes", nw, 19200);
      chk("clr_pixel_errs", pix_bad, 0);
      chk("clr_gnt_during", gnt_bad, 0);
      chk("clr_done_busy", clear_busy, 0);
      chk("clr_done_we", writeEn, 0);
      chk("clr_resume_gnt", gnt, 3'b001);
      $display("clear: writes=%0d pixel_errs=%0d done=%0d", nw, pix_bad, done_seen);
      tick;
      chk("clr_resume_we", writeEn, 1);
      chk("clr_resume_x", x, 1);
      chk("clr_done_pulse", clear_done, 0);

      // Reset in the middle of a sweep
      req = 3'b000;
      clear_go = 1'b1;
      tick;
      clear_go = 1'b0;
      nw = 0;
      for (int c = 0; c < 700; c++) begin
         if (writeEn) nw++;
         if (nw == 500) break;
         tick;
      end
      chk("mid_writes", nw, 500);
      rst = 1'b0;
      tick;
      chk("mid_rst_we", writeEn, 0);
      chk("mid_rst_busy", clear_busy, 0);
      rst = 1'b1;
      bad_cnt = 0;
      repeat (30) begin
         tick;
         if (clear_done || writeEn) bad_cnt++;
      end
      chk("mid_no_done", bad_cnt, 0);
      $display("reset mid-clear: writes=%0d stray=%0d", nw, bad_cnt);

      // Off-screen pixel
      set_req(2, 8'd200, 7'd5, 3'd7);
      req = 3'b100;
      #1;
      chk("clip_gnt", gnt, 3'b100);
      tick;
`ifdef PLOT_CLIP_EN
      chk("clip_we", writeEn, 0);
      chk("clip_hold_x", x, 0);
`else
      chk("noclip_we", writeEn, 1);
      chk("noclip_x", x, 200);
      chk("noclip_y", y, 5);
`endif
      $display("offscreen: x=%0d y=%0d we=%b", x, y, writeEn);
      req = 3'b000;
      tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
